push_pull_fifo_bridge: RTL and testbench
========================================

PUSH_PULL_FIFO_BRIDGE -- requirements
Module: push_pull_fifo_bridge

Interface
REQ-001 SHALL have parameter DataWidth, default 32, payload width in bits (>=1).
REQ-002 SHALL have parameter NumChan, default 2, number of independent channels (>=1).
REQ-003 SHALL have parameter Depth, default 4, entries per channel FIFO (>=2).
REQ-004 SHALL have parameter bit ZeroLatencyAck, default 0; 1 = ack in same cycle as req, 0 = registered ack.
REQ-005 SHALL have port clk_i  input  1  clock; one clock; all logic on its rising edge.
REQ-006 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port flush_i  input  1  synchronous clear of all channel FIFOs and FSMs.
REQ-008 SHALL have port push_valid_i  input  NumChan  per-channel push valid.
REQ-009 SHALL have port push_ready_o  output  NumChan  per-channel push ready.
REQ-010 SHALL have port push_data_i  input  NumChan x DataWidth  per-channel push payload.
REQ-011 SHALL have port pull_req_i  input  NumChan  per-channel pull request.
REQ-012 SHALL have port pull_ack_o  output  NumChan  per-channel pull acknowledge.
REQ-013 SHALL have port pull_data_o  output  NumChan x DataWidth  per-channel pull payload, valid when ack high.
REQ-014 SHALL have port depth_o  output  NumChan x $clog2(Depth+1)  per-channel occupancy.
REQ-015 SHALL have port err_o  output  NumChan  sticky per-channel protocol-violation flag.

Function
REQ-016 Channels SHALL be fully independent; no arbitration or shared state.
REQ-017 push_ready_o[c] SHALL equal !full[c] && !flush_i; no same-cycle pass-through on pop when full.
REQ-018 Push transfer SHALL occur on cycle where valid && ready; data written at tail, occupancy +1 next cycle.
REQ-019 Pull FSM per channel SHALL have states IDLE, WAIT, ACK.
REQ-020 IDLE: req && !empty -> ACK (ZeroLatencyAck=0); req && empty -> WAIT; else stay.
REQ-021 WAIT: req && !empty -> ACK; !req -> IDLE and set err_o[c].
REQ-022 ACK: pull_ack_o=1 for exactly one cycle, pull_data_o=head, head popped; next state IDLE unconditionally.
REQ-023 ZeroLatencyAck=1: ACK state SHALL be bypassed; ack=req && !empty combinationally, pop same cycle; back-to-back acks allowed with req held high (1 transfer/cycle).
REQ-024 ZeroLatencyAck=0: max throughput 1 transfer per 2 cycles per channel; req held high after ack counts as new request.
REQ-025 pull_ack_o SHALL never be 1 while pull_req_i is 0 in ZeroLatencyAck=1; in mode 0 req drop in the ACK cycle SHALL set err_o, ack still completes.
REQ-026 pull_data_o SHALL be 0 whenever pull_ack_o is 0.
REQ-027 Simultaneous push and pop on same channel SHALL leave occupancy unchanged; permitted at full only via pop (ready low) and at empty only in no case (pop requires !empty before push).
REQ-028 Pointers SHALL wrap modulo Depth; Depth need not be a power of two.
REQ-029 flush_i SHALL empty all FIFOs and force FSMs to IDLE next cycle, overriding push/pop that cycle; err_o unaffected.

Reset
REQ-030 On rst_ni low: push_ready_o=all 1, pull_ack_o=0, pull_data_o=0, depth_o=0, err_o=0, FSMs IDLE, pointers 0.
REQ-031 Reset asserted mid-transfer SHALL discard all stored data and any pending ack immediately (asynchronous).
REQ-032 err_o SHALL clear only on reset.

Structure
REQ-033 Package push_pull_fifo_bridge_pkg SHALL hold the pull FSM state enum (IDLE, WAIT, ACK).
REQ-034 Per-channel logic SHALL live in sub-module push_pull_fifo_bridge_chan, instantiated NumChan times via generate.
REQ-035 FIFO storage SHALL be flops, no memory macro.

Verification
REQ-036 Fill: Depth=4, push 0xA1..0xA4 on ch0 no req -> depth_o[0]=4, push_ready_o[0]=0, 5th push stalls.
REQ-037 Order: mode 0, push 0x11,0x22, hold req high -> acks 2 cycles apart with 0x11 then 0x22, then WAIT.
REQ-038 Zero latency: ZeroLatencyAck=1, 3 entries, req high 3 cycles -> ack 3 consecutive cycles, depth 3->0.
REQ-039 Violation: req high on empty ch1 2 cycles, then drop -> err_o[1]=1 sticky, err_o[0]=0.
REQ-040 Flush: depth 3, flush_i pulse with push_valid high -> depth_o=0 next cycle, no ack, push dropped.
REQ-041 Async reset during ACK state -> pull_ack_o=0 and depth_o=0 before next clock edge.

Source files
------------

// File: rtl/push_pull_fifo_bridge_pkg.sv
// Shared types for the push/pull FIFO bridge: the per-channel pull handshake states.
package push_pull_fifo_bridge_pkg;

    typedef enum logic [1:0] {
        PULL_IDLE = 2'd0,
        PULL_WAIT = 2'd1,
        PULL_ACK  = 2'd2
    } pull_state_e;

endpackage

// File: rtl/push_pull_fifo_bridge_chan.sv
// One bridge channel: flop-based FIFO filled by a valid/ready push side and
// drained by a req/ack pull FSM with optional zero-latency acknowledge.
module push_pull_fifo_bridge_chan
    import push_pull_fifo_bridge_pkg::*;
#(
    parameter int DataWidth      = 32,
    parameter int Depth          = 4,
    parameter bit ZeroLatencyAck = 1'b0
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         flush_i,
    input  logic                         push_valid_i,
    output logic                         push_ready_o,
    input  logic [DataWidth-1:0]         push_data_i,
    input  logic                         pull_req_i,
    output logic                         pull_ack_o,
    output logic [DataWidth-1:0]         pull_data_o,
    output logic [$clog2(Depth+1)-1:0]   depth_o,
    output logic                         err_o
);

    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CntW = $clog2(Depth + 1);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);

    logic [DataWidth-1:0] mem_q [Depth];
    logic [PtrW-1:0]      wr_ptr_q;
    logic [PtrW-1:0]      rd_ptr_q;
    logic [CntW-1:0]      count_q;
    pull_state_e          state_q;
    pull_state_e          state_d;
    logic                 err_q;
    logic                 err_set;
    logic                 full;
    logic                 empty;
    logic                 push_fire;
    logic                 pop;

    // Pointers wrap at Depth explicitly so non-power-of-two depths work.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
        return (ptr == LastPtr) ? '0 : ptr + 1'b1;
    endfunction

    assign full         = (count_q == CntW'(Depth));
    assign empty        = (count_q == '0);
    assign push_ready_o = !full && !flush_i;
    assign push_fire    = push_valid_i && push_ready_o;

    always_comb begin
        state_d = state_q;
        err_set = 1'b0;
        pop     = 1'b0;
        if (ZeroLatencyAck) begin
            pop = pull_req_i && !empty && !flush_i;
            case (state_q)
                PULL_WAIT: begin
                    if (!pull_req_i) begin
                        state_d = PULL_IDLE;
                        err_set = 1'b1;
                    end else if (!empty) begin
                        state_d = PULL_IDLE;
                    end
                end
                default: state_d = (pull_req_i && empty) ? PULL_WAIT : PULL_IDLE;
            endcase
        end else begin
            case (state_q)
                PULL_IDLE: begin
                    if (pull_req_i) state_d = empty ? PULL_WAIT : PULL_ACK;
                end
                PULL_WAIT: begin
                    if (!pull_req_i) begin
                        state_d = PULL_IDLE;
                        err_set = 1'b1;
                    end else if (!empty) begin
                        state_d = PULL_ACK;
                    end
                end
                PULL_ACK: begin
                    // A request dropped mid-ack is flagged but the ack still completes.
                    pop     = !flush_i;
                    state_d = PULL_IDLE;
                    err_set = !pull_req_i;
                end
                default: state_d = PULL_IDLE;
            endcase
        end
        if (flush_i) state_d = PULL_IDLE;
    end

    assign pull_ack_o  = pop;
    assign pull_data_o = pop ? mem_q[rd_ptr_q] : '0;
    assign depth_o     = count_q;
    assign err_o       = err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= PULL_IDLE;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (err_set) err_q <= 1'b1;
            if (flush_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push_fire) wr_ptr_q <= ptr_inc(wr_ptr_q);
                if (pop)       rd_ptr_q <= ptr_inc(rd_ptr_q);
                case ({push_fire, pop})
                    2'b10:   count_q <= count_q + 1'b1;
                    2'b01:   count_q <= count_q - 1'b1;
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    // Storage is data only; validity is tracked by the reset pointers/count.
    always_ff @(posedge clk_i) begin
        if (push_fire) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/push_pull_fifo_bridge.sv
// Multi-channel push/pull bridge: NumChan fully independent FIFO channels.
module push_pull_fifo_bridge
    import push_pull_fifo_bridge_pkg::*;
#(
    parameter int DataWidth      = 32,
    parameter int NumChan        = 2,
    parameter int Depth          = 4,
    parameter bit ZeroLatencyAck = 1'b0
) (
    input  logic                                       clk_i,
    input  logic                                       rst_ni,
    input  logic                                       flush_i,
    input  logic [NumChan-1:0]                         push_valid_i,
    output logic [NumChan-1:0]                         push_ready_o,
    input  logic [NumChan-1:0][DataWidth-1:0]          push_data_i,
    input  logic [NumChan-1:0]                         pull_req_i,
    output logic [NumChan-1:0]                         pull_ack_o,
    output logic [NumChan-1:0][DataWidth-1:0]          pull_data_o,
    output logic [NumChan-1:0][$clog2(Depth+1)-1:0]    depth_o,
    output logic [NumChan-1:0]                         err_o
);

    for (genvar c = 0; c < NumChan; c++) begin : g_chan
        push_pull_fifo_bridge_chan #(
            .DataWidth      (DataWidth),
            .Depth          (Depth),
            .ZeroLatencyAck (ZeroLatencyAck)
        ) u_chan (
            .clk_i        (clk_i),
            .rst_ni       (rst_ni),
            .flush_i      (flush_i),
            .push_valid_i (push_valid_i[c]),
            .push_ready_o (push_ready_o[c]),
            .push_data_i  (push_data_i[c]),
            .pull_req_i   (pull_req_i[c]),
            .pull_ack_o   (pull_ack_o[c]),
            .pull_data_o  (pull_data_o[c]),
            .depth_o      (depth_o[c]),
            .err_o        (err_o[c])
        );
    end

endmodule

// File: tb/tb_push_pull_fifo_bridge.sv
// Scoreboard bench: a registered-ack bridge (dut0) and a zero-latency bridge (dut1).
module tb_push_pull_fifo_bridge;

    typedef logic [31:0] word_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n0, rst_n1, flush0, flush1;
    logic [1:0]        pv0, pv1, pr0, pr1, req0, req1, ack0, ack1, err0, err1;
    logic [1:0][31:0]  pd0, pd1, pdo0, pdo1;
    logic [1:0][2:0]   dep0, dep1;

    int checks = 0;
    int errors = 0;
    word_t sb [4][$];

    push_pull_fifo_bridge #(.DataWidth(32), .NumChan(2), .Depth(4), .ZeroLatencyAck(1'b0)) dut0 (
        .clk_i(clk), .rst_ni(rst_n0), .flush_i(flush0),
        .push_valid_i(pv0), .push_ready_o(pr0), .push_data_i(pd0),
        .pull_req_i(req0), .pull_ack_o(ack0), .pull_data_o(pdo0),
        .depth_o(dep0), .err_o(err0)
    );

    push_pull_fifo_bridge #(.DataWidth(32), .NumChan(2), .Depth(4), .ZeroLatencyAck(1'b1)) dut1 (
        .clk_i(clk), .rst_ni(rst_n1), .flush_i(flush1),
        .push_valid_i(pv1), .push_ready_o(pr1), .push_data_i(pd1),
        .pull_req_i(req1), .pull_ack_o(ack1), .pull_data_o(pdo1),
        .depth_o(dep1), .err_o(err1)
    );

    // Output monitor: every ack pops the expected word for that channel.
    always @(negedge clk) begin
        word_t exp;
        for (int c = 0; c < 2; c++) begin
            if (ack0[c]) begin
                checks++;
                if (sb[c].size() == 0) begin
                    errors++;
                    $display("FAIL dut0_unexpected_ack ch%0d got %h, expected no ack", c, pdo0[c]);
                end else begin
                    exp = sb[c].pop_front();
                    if (pdo0[c] !== exp) begin
                        errors++;
                        $display("FAIL dut0_pull_data ch%0d got %h expected %h", c, pdo0[c], exp);
                    end
                end
            end else begin
                checks++;
                if (pdo0[c] !== 32'h0) begin
                    errors++;
                    $display("FAIL dut0_idle_data ch%0d got %h expected 0", c, pdo0[c]);
                end
            end
            if (ack1[c]) begin
                checks++;
                if (!req1[c]) begin
                    errors++;
                    $display("FAIL dut1_ack_without_req ch%0d ack=1 req=0, expected ack=0", c);
                end
                if (sb[2+c].size() == 0) begin
                    errors++;
                    $display("FAIL dut1_unexpected_ack ch%0d got %h, expected no ack", c, pdo1[c]);
                end else begin
                    exp = sb[2+c].pop_front();
                    if (pdo1[c] !== exp) begin
                        errors++;
                        $display("FAIL dut1_pull_data ch%0d got %h expected %h", c, pdo1[c], exp);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push0(input int ch, input word_t d);
        pv0[ch] = 1'b1;
        pd0[ch] = d;
        sb[ch].push_back(d);
        step();
        pv0[ch] = 1'b0;
    endtask

    task automatic push1(input int ch, input word_t d);
        pv1[ch] = 1'b1;
        pd1[ch] = d;
        sb[2+ch].push_back(d);
        step();
        pv1[ch] = 1'b0;
    endtask

    task automatic test_reset();
        rst_n0 = 1'b0; rst_n1 = 1'b0; flush0 = 1'b0; flush1 = 1'b0;
        pv0 = '0; pv1 = '0; pd0 = '0; pd1 = '0; req0 = '0; req1 = '0;
        @(negedge clk); @(negedge clk);
        checks++;
        if (pr0 !== 2'b11 || pr1 !== 2'b11) begin
            errors++; $display("FAIL reset_ready got %b/%b expected 11/11", pr0, pr1);
        end
        checks++;
        if (ack0 !== 2'b00 || ack1 !== 2'b00) begin
            errors++; $display("FAIL reset_ack got %b/%b expected 00/00", ack0, ack1);
        end
        checks++;
        if (dep0 !== '0 || dep1 !== '0 || err0 !== 2'b00 || err1 !== 2'b00) begin
            errors++; $display("FAIL reset_depth_err got %h/%h err %b/%b expected 0", dep0, dep1, err0, err1);
        end
        @(posedge clk); #1;
        rst_n0 = 1'b1; rst_n1 = 1'b1;
        step();
    endtask

    task automatic test_fill();
        for (int i = 0; i < 4; i++) push0(0, 32'hA1 + i);
        checks++;
        if (dep0[0] !== 3'd4 || pr0[0] !== 1'b0) begin
            errors++; $display("FAIL fill_full depth %0d ready %b expected 4 0", dep0[0], pr0[0]);
        end
        pv0[0] = 1'b1; pd0[0] = 32'hA5;
        step();
        pv0[0] = 1'b0;
        checks++;
        if (dep0[0] !== 3'd4) begin
            errors++; $display("FAIL fill_stall depth %0d expected 4", dep0[0]);
        end
        req0[0] = 1'b1;
        repeat (8) step();
        req0[0] = 1'b0;
        checks++;
        if (dep0[0] !== 3'd0 || err0[0] !== 1'b0) begin
            errors++; $display("FAIL fill_drain depth %0d err %b expected 0 0", dep0[0], err0[0]);
        end
    endtask

    task automatic test_violation();
        req0[1] = 1'b1;
        step(); step();
        req0[1] = 1'b0;
        step();
        checks++;
        if (err0 !== 2'b10) begin
            errors++; $display("FAIL violation_err got %b expected 10", err0);
        end
        repeat (3) step();
        checks++;
        if (err0[1] !== 1'b1) begin
            errors++; $display("FAIL violation_sticky got %b expected 1", err0[1]);
        end
    endtask

    task automatic test_order();
        int n_ack = 0;
        int pos [2] = '{-1, -1};
        push0(0, 32'h11);
        push0(0, 32'h22);
        req0[0] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ack0[0]) begin
                if (n_ack < 2) pos[n_ack] = i;
                n_ack++;
            end
        end
        checks++;
        if (n_ack != 2 || pos[0] != 1 || pos[1] != 3) begin
            errors++; $display("FAIL order_ack_timing count %0d at %0d,%0d expected 2 at 1,3", n_ack, pos[0], pos[1]);
        end
        @(posedge clk); #1;
        pv0[0] = 1'b1; pd0[0] = 32'h33; sb[0].push_back(32'h33);
        step();
        pv0[0] = 1'b0;
        step(); step();
        req0[0] = 1'b0;
        checks++;
        if (dep0[0] !== 3'd0 || err0[0] !== 1'b0) begin
            errors++; $display("FAIL order_wait_resume depth %0d err %b expected 0 0", dep0[0], err0[0]);
        end
    endtask

    task automatic test_zero_latency();
        for (int i = 0; i < 3; i++) push1(0, 32'hC1 + i);
        req1[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (ack1[0] !== 1'b1 || dep1[0] !== 3'(3 - i)) begin
                errors++; $display("FAIL zl_b2b cycle %0d ack %b depth %0d expected 1 %0d", i, ack1[0], dep1[0], 3 - i);
            end
        end
        @(posedge clk); #1;
        req1[0] = 1'b0;
        checks++;
        if (dep1[0] !== 3'd0 || err1[0] !== 1'b0) begin
            errors++; $display("FAIL zl_drained depth %0d err %b expected 0 0", dep1[0], err1[0]);
        end
    endtask

    task automatic test_simultaneous();
        push1(1, 32'hD1);
        pv1[1] = 1'b1; pd1[1] = 32'hD2; sb[3].push_back(32'hD2);
        req1[1] = 1'b1;
        @(negedge clk);
        checks++;
        if (ack1[1] !== 1'b1 || dep1[1] !== 3'd1) begin
            errors++; $display("FAIL simul_first ack %b depth %0d expected 1 1", ack1[1], dep1[1]);
        end
        step();
        pv1[1] = 1'b0;
        checks++;
        if (dep1[1] !== 3'd1) begin
            errors++; $display("FAIL simul_depth got %0d expected 1", dep1[1]);
        end
        step();
        req1[1] = 1'b0;
        checks++;
        if (dep1[1] !== 3'd0) begin
            errors++; $display("FAIL simul_drain got %0d expected 0", dep1[1]);
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) push0(0, 32'h51 + i);
        flush0 = 1'b1; pv0[0] = 1'b1; pd0[0] = 32'h99;
        @(negedge clk);
        checks++;
        if (pr0 !== 2'b00 || ack0[0] !== 1'b0) begin
            errors++; $display("FAIL flush_ready ready %b ack %b expected 00 0", pr0, ack0[0]);
        end
        step();
        flush0 = 1'b0; pv0[0] = 1'b0;
        sb[0].delete();
        checks++;
        if (dep0[0] !== 3'd0 || err0[1] !== 1'b1) begin
            errors++; $display("FAIL flush_empty depth %0d err1 %b expected 0 1", dep0[0], err0[1]);
        end
        @(negedge clk);
        checks++;
        if (ack0[0] !== 1'b0 || dep0[0] !== 3'd0) begin
            errors++; $display("FAIL flush_no_ack ack %b depth %0d expected 0 0", ack0[0], dep0[0]);
        end
    endtask

    task automatic test_reset_mid_ack();
        bit found = 1'b0;
        push0(0, 32'hE1);
        push0(0, 32'hE2);
        req0[0] = 1'b1;
        for (int i = 0; i < 6 && !found; i++) begin
            @(negedge clk);
            if (ack0[0]) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL rst_ack_timeout ack never seen, expected within 6 cycles");
        end
        #1 rst_n0 = 1'b0;
        #1;
        checks++;
        if (ack0[0] !== 1'b0 || dep0[0] !== 3'd0 || pr0 !== 2'b11 || err0 !== 2'b00) begin
            errors++; $display("FAIL rst_async ack %b depth %0d ready %b err %b expected 0 0 11 00", ack0[0], dep0[0], pr0, err0);
        end
        sb[0].delete();
        req0[0] = 1'b0;
        @(posedge clk); #1;
        rst_n0 = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_fill();
        test_violation();
        test_order();
        test_zero_latency();
        test_simultaneous();
        test_flush();
        test_reset_mid_ack();
        repeat (2) step();
        for (int q = 0; q < 4; q++) begin
            checks++;
            if (sb[q].size() != 0) begin
                errors++; $display("FAIL sb_leftover queue %0d holds %0d entries, expected 0", q, sb[q].size());
            end
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
